// File: rtl/rc4_keystream_decrypt.sv
// RC4 keystream generator and decrypt stage: walks a key-scheduled S memory
// with the PRGA, XORs each keystream byte with the encrypted ROM, and writes
// the plaintext byte to the decrypted RAM.
//
// Memory handshake (S, E and D ports alike): an issue state registers the
// address, write data, readWrite and start=1. The following wait state holds
// all of them stable until finish is sampled high. In that cycle start drops,
// any read data is captured, and the FSM advances. Only one operation is ever
// outstanding, and a finish pulse on a port the FSM is not waiting on is
// ignored.
module rc4_keystream_decrypt #(
    parameter logic [8:0] message_length = 9'd32
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] S_address,
    output logic [7:0] S_data_out,
    input  logic [7:0] S_data_in,
    output logic       S_readWrite,
    output logic       S_start_readWrite_op,
    input  logic       S_finish_readWrite_op,
    output logic [7:0] E_address,
    input  logic [7:0] E_data_in,
    output logic       E_start_read_op,
    input  logic       E_finish_read_op,
    output logic [7:0] D_address,
    output logic [7:0] D_data_out,
    output logic       D_readWrite,
    output logic       D_start_readWrite_op,
    input  logic       D_finish_readWrite_op,
    input  logic       start_Task2b,
    output logic       finish_Task2b
);

    typedef enum logic [4:0] {
        IDLE, INC_I, RD_SI, WT_SI, CALC_J, RD_SJ, WT_SJ,
        WR_SI, WT_WR_SI, WR_SJ, WT_WR_SJ, RD_F, WT_F,
        RD_E, WT_E, WR_D, WT_WR_D, NEXT_K, FINISHED
    } state_t;

    // k is 8 bits; the last byte is found by equality, so length 256 fits.
    localparam logic [8:0] LAST_K_W = message_length - 9'd1;
    localparam logic [7:0] LAST_K   = LAST_K_W[7:0];

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
    logic [7:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic       s_rw_q, s_rw_d, s_start_q, s_start_d;
    logic [7:0] e_addr_q, e_addr_d;
    logic       e_start_q, e_start_d;
    logic [7:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic       d_rw_q, d_rw_d, d_start_q, d_start_d;
    logic       finish_q, finish_d;

    // Next-state and registered-output logic; everything holds by default.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        e_d       = e_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_rw_d    = s_rw_q;
        s_start_d = s_start_q;
        e_addr_d  = e_addr_q;
        e_start_d = e_start_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_rw_d    = d_rw_q;
        d_start_d = d_start_q;
        finish_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_Task2b) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 8'd0;
                    state_d = INC_I;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_SI;
            end
            RD_SI: begin
                s_addr_d  = i_q;
                s_rw_d    = 1'b0;
                s_start_d = 1'b1;
                state_d   = WT_SI;
            end
            WT_SI: begin
                if (S_finish_readWrite_op) begin
                    s_start_d = 1'b0;
                    si_d      = S_data_in;
                    state_d   = CALC_J;
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                s_addr_d  = j_q;
                s_rw_d    = 1'b0;
                s_start_d = 1'b1;
                state_d   = WT_SJ;
            end
            WT_SJ: begin
                if (S_finish_readWrite_op) begin
                    s_start_d = 1'b0;
                    sj_d      = S_data_in;
                    state_d   = WR_SI;
                end
            end
            WR_SI: begin
                s_addr_d  = i_q;
                s_wdata_d = sj_q;
                s_rw_d    = 1'b1;
                s_start_d = 1'b1;
                state_d   = WT_WR_SI;
            end
            WT_WR_SI: begin
                if (S_finish_readWrite_op) begin
                    s_start_d = 1'b0;
                    state_d   = WR_SJ;
                end
            end
            // When i==j this rewrites the same cell with the same value.
            WR_SJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_rw_d    = 1'b1;
                s_start_d = 1'b1;
                state_d   = WT_WR_SJ;
            end
            WT_WR_SJ: begin
                if (S_finish_readWrite_op) begin
                    s_start_d = 1'b0;
                    state_d   = RD_F;
                end
            end
            RD_F: begin
                s_addr_d  = si_q + sj_q;
                s_rw_d    = 1'b0;
                s_start_d = 1'b1;
                state_d   = WT_F;
            end
            WT_F: begin
                if (S_finish_readWrite_op) begin
                    s_start_d = 1'b0;
                    f_d       = S_data_in;
                    state_d   = RD_E;
                end
            end
            RD_E: begin
                e_addr_d  = k_q;
                e_start_d = 1'b1;
                state_d   = WT_E;
            end
            WT_E: begin
                if (E_finish_read_op) begin
                    e_start_d = 1'b0;
                    e_d       = E_data_in;
                    state_d   = WR_D;
                end
            end
            WR_D: begin
                d_addr_d  = k_q;
                d_wdata_d = f_q ^ e_q;
                d_rw_d    = 1'b1;
                d_start_d = 1'b1;
                state_d   = WT_WR_D;
            end
            WT_WR_D: begin
                if (D_finish_readWrite_op) begin
                    d_start_d = 1'b0;
                    state_d   = NEXT_K;
                end
            end
            NEXT_K: begin
                if (k_q == LAST_K) begin
                    state_d = FINISHED;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = INC_I;
                end
            end
            // The done pulse is registered out of this state.
            FINISHED: begin
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            f_q       <= 8'd0;
            e_q       <= 8'd0;
            s_addr_q  <= 8'd0;
            s_wdata_q <= 8'd0;
            s_rw_q    <= 1'b0;
            s_start_q <= 1'b0;
            e_addr_q  <= 8'd0;
            e_start_q <= 1'b0;
            d_addr_q  <= 8'd0;
            d_wdata_q <= 8'd0;
            d_rw_q    <= 1'b0;
            d_start_q <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            f_q       <= f_d;
            e_q       <= e_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_rw_q    <= s_rw_d;
            s_start_q <= s_start_d;
            e_addr_q  <= e_addr_d;
            e_start_q <= e_start_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_rw_q    <= d_rw_d;
            d_start_q <= d_start_d;
            finish_q  <= finish_d;
        end
    end

    assign S_address            = s_addr_q;
    assign S_data_out           = s_wdata_q;
    assign S_readWrite          = s_rw_q;
    assign S_start_readWrite_op = s_start_q;
    assign E_address            = e_addr_q;
    assign E_start_read_op      = e_start_q;
    assign D_address            = d_addr_q;
    assign D_data_out           = d_wdata_q;
    assign D_readWrite          = d_rw_q;
    assign D_start_readWrite_op = d_start_q;
    assign finish_Task2b        = finish_q;

endmodule
